// File: rtl/mem_port_arbiter.sv
//============================================================================
// Module   : mem_port_arbiter
// Purpose  : Serialises IF and LS accesses onto one fixed-latency SRAM port.
//            Optional wait-cycle counters are built when MEM_ARB_PERF_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_bmask,
  output logic [31:0]       ls_rdata,
  output logic              ls_rvalid,
  output logic              ls_stall,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_bmask,
  input  logic [31:0]       sram_rdata,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_ls_wait
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_own_ls;
  logic              r_we;
  logic [1:0]        r_cnt;
  logic              r_sram_ce;
  logic              r_sram_we;
  logic [ADDR_W-3:0] r_sram_addr;
  logic [31:0]       r_sram_wdata;
  logic [3:0]        r_sram_bmask;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_ls_rdata;
  logic              r_if_rvalid;
  logic              r_ls_rvalid;

  logic w_grant;
  logic w_store;
  logic w_capture;
  logic w_unused;

  assign w_grant   = (r_state == S_IDLE) && (ls_req || if_req);
  assign w_store   = ls_req && ls_we;
  assign w_capture = (r_state == S_WAIT) && (r_cnt == 2'd0);
  assign w_unused  = ^{if_addr[1:0], ls_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ls_req || if_req) w_next = S_ISSUE;
      S_ISSUE: w_next = (r_own_ls && r_we) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 2'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_own_ls     <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= 2'd0;
      r_sram_ce    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= 32'h0;
      r_sram_bmask <= 4'h0;
      r_if_rdata   <= 32'h0;
      r_ls_rdata   <= 32'h0;
      r_if_rvalid  <= 1'b0;
      r_ls_rvalid  <= 1'b0;
    end else begin
      // SRAM strobes are loaded on grant so they are live only during ISSUE
      r_sram_ce    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= 32'h0;
      r_sram_bmask <= 4'h0;
      r_if_rvalid  <= 1'b0;
      r_ls_rvalid  <= 1'b0;

      if (w_grant) begin
        r_own_ls     <= ls_req;
        r_we         <= w_store;
        r_sram_ce    <= 1'b1;
        r_sram_we    <= w_store;
        r_sram_addr  <= ls_req ? ls_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
        r_sram_wdata <= w_store ? ls_wdata : 32'h0;
        r_sram_bmask <= w_store ? ls_bmask : 4'hF;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= 2'(RD_LAT - 1);
        if (r_own_ls && r_we) r_ls_rvalid <= 1'b1;
      end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end

      // A fetch whose request has gone away by capture time is a flushed one
      if (w_capture) begin
        if (r_own_ls) begin
          r_ls_rdata  <= sram_rdata;
          r_ls_rvalid <= 1'b1;
        end else if (if_req) begin
          r_if_rdata  <= sram_rdata;
          r_if_rvalid <= 1'b1;
        end
      end
    end
  end

  assign sram_ce    = r_sram_ce;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_bmask = r_sram_bmask;
  assign if_rdata   = r_if_rdata;
  assign ls_rdata   = r_ls_rdata;
  assign if_rvalid  = r_if_rvalid;
  assign ls_rvalid  = r_ls_rvalid;
  assign if_stall   = if_req && !r_if_rvalid;
  assign ls_stall   = ls_req && !r_ls_rvalid;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_if;
  logic [31:0] r_perf_ls;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_perf_if <= 32'h0;
      r_perf_ls <= 32'h0;
    end else begin
      if (if_stall) r_perf_if <= r_perf_if + 32'd1;
      if (ls_stall) r_perf_ls <= r_perf_ls + 32'd1;
    end
  end

  assign perf_if_wait = r_perf_if;
  assign perf_ls_wait = r_perf_ls;
`else
  assign perf_if_wait = 32'h0;
  assign perf_ls_wait = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with a behavioural SRAM.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;
  localparam int NWORDS = 1 << (ADDR_W - 2);

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_rvalid;
  logic              if_stall;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic [3:0]        ls_bmask;
  logic [31:0]       ls_rdata;
  logic              ls_rvalid;
  logic              ls_stall;
  logic              sram_ce;
  logic              sram_we;
  logic [ADDR_W-3:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [3:0]        sram_bmask;
  logic [31:0]       sram_rdata;
  logic [31:0]       perf_if_wait;
  logic [31:0]       perf_ls_wait;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        if_q[$];
  exp_t        ls_q[$];
  exp_t        mon_if_e;
  exp_t        mon_ls_e;
  logic [31:0] ref_mem [0:NWORDS-1];
  logic [31:0] ls_last = 32'h0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_rvalid    (if_rvalid),
    .if_stall     (if_stall),
    .ls_req       (ls_req),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_bmask     (ls_bmask),
    .ls_rdata     (ls_rdata),
    .ls_rvalid    (ls_rvalid),
    .ls_stall     (ls_stall),
    .sram_ce      (sram_ce),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_bmask   (sram_bmask),
    .sram_rdata   (sram_rdata),
    .perf_if_wait (perf_if_wait),
    .perf_ls_wait (perf_ls_wait)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
  endfunction

  // Behavioural SRAM: unwritten words read back the power-on pattern
  logic [31:0] sr_mem     [0:NWORDS-1];
  bit          sr_written [0:NWORDS-1];
  logic [31:0] sr_pipe    [0:RD_LAT-1];
  logic [31:0] sr_base;
  logic [31:0] sr_new;

  always @(posedge clk) begin
    sr_base = sr_written[sram_addr] ? sr_mem[sram_addr] : pat(int'(sram_addr));
    if (sram_ce) begin
      if (sram_we) begin
        sr_new = sr_base;
        for (int b = 0; b < 4; b++)
          if (sram_bmask[b]) sr_new[8*b +: 8] = sram_wdata[8*b +: 8];
        sr_mem[sram_addr]     <= sr_new;
        sr_written[sram_addr] <= 1'b1;
      end else begin
        sr_pipe[0] <= sr_base;
      end
    end
    for (int k = 1; k < RD_LAT; k++) sr_pipe[k] <= sr_pipe[k-1];
  end
  assign sram_rdata = sr_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_q.size() == 0) chk("if_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        mon_if_e = if_q.pop_front();
        chk("if_rdata", if_rdata, mon_if_e.d);
        chk("if_latency", 32'(cyc), 32'(mon_if_e.c));
      end
    end
    if (ls_rvalid) begin
      if (ls_q.size() == 0) chk("ls_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        mon_ls_e = ls_q.pop_front();
        chk("ls_rdata", ls_rdata, mon_ls_e.d);
        chk("ls_latency", 32'(cyc), 32'(mon_ls_e.c));
      end
    end
  end

  task automatic if_read(input logic [ADDR_W-1:0] a, input int extra);
    int t;
    int n;
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = a;
    t = cyc;
    if_q.push_back('{ref_mem[a[ADDR_W-1:2]], t + 2 + RD_LAT + extra});
    @(negedge clk);
    chk("if_stall_req", 32'(if_stall), 32'd1);
    if (extra == 0) begin
      chk("if_ls_stall_idle", 32'(ls_stall), 32'd0);
      @(negedge clk);
      chk("if_sram_ce", 32'(sram_ce), 32'd1);
      chk("if_sram_we", 32'(sram_we), 32'd0);
      chk("if_sram_addr", 32'(sram_addr), 32'(a[ADDR_W-1:2]));
      chk("if_sram_bmask", 32'(sram_bmask), 32'hF);
    end
    n = 0;
    while (!if_rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!if_rvalid) chk("if_timeout", 32'd0, 32'd1);
    else            chk("if_stall_rvalid", 32'(if_stall), 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic ls_access(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [31:0] wd, input logic [3:0] bm, input int extra);
    int t;
    int n;
    @(posedge clk); #1;
    ls_req   = 1'b1;
    ls_we    = we;
    ls_addr  = a;
    ls_wdata = wd;
    ls_bmask = bm;
    t = cyc;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (bm[b]) ref_mem[a[ADDR_W-1:2]][8*b +: 8] = wd[8*b +: 8];
      ls_q.push_back('{ls_last, t + 2 + extra});
    end else begin
      ls_last = ref_mem[a[ADDR_W-1:2]];
      ls_q.push_back('{ls_last, t + 2 + RD_LAT + extra});
    end
    @(negedge clk);
    chk("ls_stall_req", 32'(ls_stall), 32'd1);
    if (extra == 0) begin
      @(negedge clk);
      chk("ls_sram_ce", 32'(sram_ce), 32'd1);
      chk("ls_sram_we", 32'(sram_we), 32'(we));
      chk("ls_sram_addr", 32'(sram_addr), 32'(a[ADDR_W-1:2]));
      chk("ls_sram_bmask", 32'(sram_bmask), we ? 32'(bm) : 32'hF);
      if (we) chk("ls_sram_wdata", sram_wdata, wd);
    end
    n = 0;
    while (!ls_rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ls_rvalid) chk("ls_timeout", 32'd0, 32'd1);
    else            chk("ls_stall_rvalid", 32'(ls_stall), 32'd0);
    @(posedge clk); #1;
    ls_req = 1'b0;
    ls_we  = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_if_rdata"},  if_rdata, 32'h0);
    chk({pfx, "_ls_rdata"},  ls_rdata, 32'h0);
    chk({pfx, "_rvalids"},   32'({if_rvalid, ls_rvalid}), 32'h0);
    chk({pfx, "_stalls"},    32'({if_stall, ls_stall}), 32'h0);
    chk({pfx, "_sram_ctl"},  32'({sram_ce, sram_we, sram_bmask}), 32'h0);
    chk({pfx, "_sram_addr"}, 32'(sram_addr), 32'h0);
    chk({pfx, "_sram_wd"},   sram_wdata, 32'h0);
    chk({pfx, "_perf_if"},   perf_if_wait, 32'h0);
    chk({pfx, "_perf_ls"},   perf_ls_wait, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] keep;
    logic [31:0] p_if;
    logic [31:0] p_ls;
    int          n;

    for (int i = 0; i < NWORDS; i++) ref_mem[i] = pat(i);
    rst_n    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_wdata = 32'h0;
    ls_bmask = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst0");
    @(posedge clk); #1;
    rst_n = 1'b0;

    if_read(16'h0040, 0);
    ls_access(1'b1, 16'h0104, 32'h11223344, 4'b0011, 0);
    ls_access(1'b0, 16'h0104, 32'h0, 4'h0, 0);
    if_read(16'h0104, 0);

    // Same-cycle requests: LS wins, IF granted in the IDLE after LS completes
    fork
      if_read(16'h0108, 3 + RD_LAT);
      ls_access(1'b0, 16'h0040, 32'h0, 4'h0, 0);
    join

    // IF abandon while the read is in flight
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = 16'h0080;
    keep    = if_rdata;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_req = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_rvalid) n++;
    end
    chk("abandon_no_rvalid", 32'(n), 32'd0);
    chk("abandon_if_rdata", if_rdata, keep);
    ls_access(1'b0, 16'h0200, 32'h0, 4'h0, 0);

    @(negedge clk);
    p_if = perf_if_wait;
    p_ls = perf_ls_wait;
    if_read(16'h0300, 0);
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    chk("perf_if_delta", perf_if_wait - p_if, 32'(RD_LAT + 2));
    chk("perf_ls_delta", perf_ls_wait - p_ls, 32'h0);
`else
    chk("perf_if_off", perf_if_wait, 32'h0);
    chk("perf_ls_off", perf_ls_wait, 32'h0);
`endif

    // Reset in the middle of a fetch read
    @(posedge clk); #1;
    if_req  = 1'b1;
    if_addr = 16'h0020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    if_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("rst1");
    @(posedge clk); #1;
    rst_n   = 1'b0;
    ls_last = 32'h0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid) n++;
    end
    chk("rst_no_rvalid", 32'(n), 32'd0);
    if_read(16'h0010, 0);

    repeat (4) @(negedge clk);
    chk("if_queue_drained", 32'(if_q.size()), 32'd0);
    chk("ls_queue_drained", 32'(ls_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-port, fixed-latency unified SRAM shared by two requesters: instruction fetch (IF) and the load/store unit (LS).
- Sits between the fetch stage, the memory stage and the SRAM macro.
- Serialises accesses, counts read latency and returns registered read data.
- Raises per-requester stall signals that the hazard logic uses to freeze the PC and the pipeline registers.

Parameters:
- ADDR_W, 16: byte-address width of both requesters. The SRAM word address is ADDR_W-2 bits.
- RD_LAT, 1: SRAM read latency in cycles from the cycle sram_ce is high to the cycle sram_rdata is valid. Legal range 1..4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-high reset (asserted high despite the _n suffix)
- if_req  in  1  fetch read request, held until if_rvalid or abandoned
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  32  fetched word
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_stall  out  1  fetch waiting
- ls_req  in  1  LS request, held stable until ls_rvalid
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  LS byte address
- ls_wdata  in  32  store data
- ls_bmask  in  4  store byte enables
- ls_rdata  out  32  load word
- ls_rvalid  out  1  one-cycle pulse, load data valid or store done
- ls_stall  out  1  LS waiting
- sram_ce  out  1  SRAM access strobe
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W-2  word address
- sram_wdata  out  32  write data
- sram_bmask  out  4  byte enables
- sram_rdata  in  32  SRAM read data
- perf_if_wait  out  32  IF wait-cycle count (see Optional Feature)
- perf_ls_wait  out  32  LS wait-cycle count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FSM to IDLE, latency counter 0, owner cleared. Any in-flight access is discarded and no rvalid is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if ls_req, grant LS; else if if_req, grant IF. LS has fixed priority when both request in the same cycle. On grant, latch owner, word address (addr[ADDR_W-1:2]), we, wdata and bmask; go to ISSUE.
- ISSUE (one cycle): sram_ce = 1. sram_we = 1 only for an LS store. sram_bmask = ls_bmask for a store, 4'hF for a load or fetch. Next state: store -> RESP; read -> WAIT, with the counter loaded to RD_LAT-1.
- WAIT: the counter decrements each cycle. When it is 0, capture sram_rdata into the owner's rdata register and go to RESP. With RD_LAT = 1 this is a single cycle.
- RESP (one cycle): pulse the owner's rvalid, return to IDLE. A new grant can occur only from IDLE, the cycle after RESP.
- Latency from request seen in IDLE (cycle T): rvalid in cycle T+2 for a store, T+2+RD_LAT for a read.
- Back-to-back throughput: one access every 3 cycles (store) or 3+RD_LAT cycles (read).
- sram_ce, sram_we, sram_addr, sram_wdata and sram_bmask are registered and zero outside ISSUE.
- Stalls: if_stall = if_req & ~if_rvalid; ls_stall = ls_req & ~ls_rvalid. Both are combinational from registered state.
- if_rdata and ls_rdata hold their last captured value until the next capture for the same owner.
- IF abandon (branch flush): if if_req is low in the capture cycle of an IF access, the access completes on the SRAM but if_rvalid is suppressed and if_rdata is not updated. A new if_req raised meanwhile waits for IDLE.
- LS must not drop ls_req mid-access. If it does, the access still completes and ls_rvalid still pulses.
- Address bits [1:0] are ignored; alignment is the LSU's responsibility.
- No starvation guard: IF is served whenever ls_req is low in IDLE.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: perf_if_wait increments every cycle if_stall = 1; perf_ls_wait increments every cycle ls_stall = 1. Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Not defined: both ports are tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset: rst_n = 1 for 2 cycles during a read in WAIT -> all outputs 0, no rvalid pulse after release; next if_req to 0x0010 returns the SRAM word at index 4.
- IF read, RD_LAT = 1: if_req at T, if_addr = 0x0040, SRAM word 16 = 0xDEADBEEF -> sram_ce at T+1 with sram_addr = 16; if_rvalid at T+3 with if_rdata = 0xDEADBEEF; if_stall high T..T+2.
- LS store: ls_addr = 0x0104, ls_wdata = 0x11223344, ls_bmask = 4'b0011 -> sram_we = 1, sram_addr = 65, sram_bmask = 0011 at T+1; ls_rvalid at T+2; a read of word 65 then returns the low half updated.
- Simultaneous requests: if_req and ls_req (load) at T, RD_LAT = 2 -> LS is served first with ls_rvalid at T+4; IF is granted at T+5 with if_rvalid at T+9.
- IF abandon: drop if_req in WAIT -> no if_rvalid, if_rdata unchanged, FSM back in IDLE; a following ls_req is served normally.
- Perf (macro on): IF-only read with RD_LAT = 3 -> perf_if_wait +5, perf_ls_wait unchanged; with the macro off both read 0.
